i2c_reg_arbiter: RTL and testbench
==================================

I2C_REG_ARBITER -- requirements
Module: i2c_reg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, sets the register-bank address width.
REQ-002 Parameter DATA_W, default 8, sets the register-bank data width.
REQ-003 clk  in  1  clock; all logic is on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i2c_req  in  1  access request from the I2C slave port.
REQ-006 i2c_we  in  1  1 = write, 0 = read; qualified by i2c_req.
REQ-007 i2c_addr / i2c_wdata  in  ADDR_W / DATA_W  I2C access address and write data.
REQ-008 i2c_gnt  out  1  one-cycle grant pulse to the I2C port.
REQ-009 i2c_rvalid / i2c_rdata  out  1 / DATA_W  I2C read-data pulse and read data.
REQ-010 host_req, host_we, host_addr, host_wdata  in  1, 1, ADDR_W, DATA_W  local host request, same meaning as the I2C port.
REQ-011 host_gnt, host_rvalid, host_rdata  out  1, 1, DATA_W  host grant, read-data pulse and read data.
REQ-012 mem_en, mem_we, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  drive a synchronous single-port SRAM.
REQ-013 mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en with mem_we = 0.
REQ-014 busy  out  1  high while the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP, with registered state.
REQ-016 IDLE: if any request is high, capture the winner's we/addr/wdata, latch the winner ID and go to ACCESS; otherwise stay in IDLE.
REQ-017 ACCESS (exactly one cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the captured request.
  - The winner's gnt is high for this cycle only.
  - A write returns to IDLE; a read goes to RESP.
REQ-018 RESP (exactly one cycle):
  - Register mem_rdata into the winner's rdata.
  - Set the winner's rvalid, so it is high during the following cycle only.
  - Return to IDLE.
REQ-019 Latency from a request sampled in IDLE at cycle N:
  - gnt at N+1.
  - Read rvalid/rdata at N+3.
  - Back-to-back accesses: a new arbitration in IDLE may overlap the rvalid cycle.
REQ-020 A requester SHALL hold req, we, addr and wdata stable until it sees gnt. A req still high in the cycle after gnt is a new request.
REQ-021 When no access is in progress, mem_en, mem_we, both gnt and both rvalid SHALL be 0; mem_addr and mem_wdata hold their last values.
REQ-022 The non-winning rdata SHALL hold its previous value.
REQ-023 Simultaneous requests in IDLE SHALL be resolved by the arbitration policy (REQ-027/028); the loser stays pending and is served next.
REQ-024 Requests arriving while in ACCESS/RESP are not sampled until IDLE and are never lost if held per REQ-020.
REQ-025 The arbiter SHALL NOT reorder address/data. A write then a read to the same address returns the newly written value.

Reset
REQ-026 On rst_n low the block SHALL, immediately and including mid-operation:
  - Force state = IDLE; any captured or in-flight access is discarded.
  - Drive to 0: mem_en, mem_we, mem_addr, mem_wdata, both gnt, both rvalid, both rdata, busy.
  - Set last_winner = HOST.

Configuration
REQ-027 With macro I2C_ARB_RR_EN defined: round-robin arbitration. On a tie, the port that is not last_winner wins; last_winner updates on every grant.
REQ-028 Without I2C_ARB_RR_EN: fixed priority, I2C always beats host; last_winner is not implemented.

Structure
REQ-029 A shared package SHALL hold:
  - the state enum (IDLE, ACCESS, RESP);
  - the requester-ID constants (ID_I2C = 0, ID_HOST = 1);
  - the default widths ADDR_W = 8, DATA_W = 8.
REQ-030 One sub-module, i2c_arb_pick, SHALL hold the combinational winner selection (inputs: requests and last_winner); all other logic stays in i2c_reg_arbiter.

Verification
REQ-031 Single I2C write: addr 0x10, wdata 0xA5 at N -> i2c_gnt=1 at N+1; mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 at N+1; host_gnt never asserts.
REQ-032 Host read of 0x10 after REQ-031 -> host_gnt at N+1, host_rvalid=1 with host_rdata=0xA5 at N+3; i2c_rvalid stays 0.
REQ-033 Both ports request reads simultaneously from reset, held until gnt:
  - Without I2C_ARB_RR_EN: I2C is granted first, host second.
  - With I2C_ARB_RR_EN: repeated simultaneous requests alternate I2C, host, I2C, host.
REQ-034 Host holds host_req continuously while I2C requests once -> with I2C_ARB_RR_EN the I2C port is granted within 3 cycles of its request; neither port sees two gnt pulses for one request.
REQ-035 Reset mid-read: rst_n low during ACCESS of a read -> mem_en, gnt, rvalid and busy go to 0 at once; no rvalid after reset release; next request is granted with normal N+1 latency.
REQ-036 Back-to-back I2C writes to 0x00..0xFF then reads of 0xFF and 0x00 -> read data equals written data and no address wrap error.

Source files
------------

// File: rtl/i2c_reg_arbiter_pkg.sv
// Shared types and constants for the I2C / host register-bank arbiter.
// Round-robin arbitration is selected by defining I2C_ARB_RR_EN.
package i2c_reg_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } arb_state_e;

  localparam logic ID_I2C  = 1'b0;
  localparam logic ID_HOST = 1'b1;

endpackage

// File: rtl/i2c_arb_pick.sv
// Combinational winner selection between the I2C and host requesters.
// I2C_ARB_RR_EN selects round-robin; otherwise I2C has fixed priority.
module i2c_arb_pick
  import i2c_reg_arbiter_pkg::*;
(
  input  logic i2c_req,
  input  logic host_req,
  input  logic last_winner,
  output logic any_req,
  output logic winner
);

  assign any_req = i2c_req | host_req;

`ifdef I2C_ARB_RR_EN
  always_comb begin
    winner = last_winner;
    if (i2c_req && host_req) begin
      winner = (last_winner == ID_HOST) ? ID_I2C : ID_HOST;
    end else if (i2c_req) begin
      winner = ID_I2C;
    end else if (host_req) begin
      winner = ID_HOST;
    end
  end
`else
  // With no request the result is ignored; keep the previous winner.
  always_comb begin
    winner = last_winner;
    if (i2c_req) begin
      winner = ID_I2C;
    end else if (host_req) begin
      winner = ID_HOST;
    end
  end
`endif

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Two-port (I2C slave / local host) arbiter in front of a synchronous SRAM.
// Define I2C_ARB_RR_EN for round-robin arbitration, default is I2C priority.
module i2c_reg_arbiter
  import i2c_reg_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_gnt,
  output logic              i2c_rvalid,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state_reg;
  logic              win_reg;
  logic              cap_we_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              i2c_gnt_reg;
  logic              host_gnt_reg;
  logic              i2c_rvalid_reg;
  logic              host_rvalid_reg;
  logic [DATA_W-1:0] i2c_rdata_reg;
  logic [DATA_W-1:0] host_rdata_reg;

  logic              pick_any;
  logic              pick_winner;
  logic              pick_last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef I2C_ARB_RR_EN
  logic last_winner_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_reg <= ID_HOST;
    end else if (state_reg == ST_IDLE && pick_any) begin
      last_winner_reg <= pick_winner;
    end
  end

  assign pick_last = last_winner_reg;
`else
  assign pick_last = win_reg;
`endif

  i2c_arb_pick u_pick (
    .i2c_req     (i2c_req),
    .host_req    (host_req),
    .last_winner (pick_last),
    .any_req     (pick_any),
    .winner      (pick_winner)
  );

  always_comb begin
    sel_we    = i2c_we;
    sel_addr  = i2c_addr;
    sel_wdata = i2c_wdata;
    if (pick_winner == ID_HOST) begin
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end
  end

  // The SRAM port registers double as the captured request, so the grant
  // cycle drives the memory straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      win_reg         <= ID_HOST;
      cap_we_reg      <= 1'b0;
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      i2c_gnt_reg     <= 1'b0;
      host_gnt_reg    <= 1'b0;
      i2c_rvalid_reg  <= 1'b0;
      host_rvalid_reg <= 1'b0;
      i2c_rdata_reg   <= '0;
      host_rdata_reg  <= '0;
    end else begin
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      i2c_gnt_reg     <= 1'b0;
      host_gnt_reg    <= 1'b0;
      i2c_rvalid_reg  <= 1'b0;
      host_rvalid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            win_reg       <= pick_winner;
            cap_we_reg    <= sel_we;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= sel_we;
            mem_addr_reg  <= sel_addr;
            mem_wdata_reg <= sel_wdata;
            i2c_gnt_reg   <= (pick_winner == ID_I2C);
            host_gnt_reg  <= (pick_winner == ID_HOST);
            state_reg     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_reg <= cap_we_reg ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (win_reg == ID_HOST) begin
            host_rdata_reg  <= mem_rdata;
            host_rvalid_reg <= 1'b1;
          end else begin
            i2c_rdata_reg   <= mem_rdata;
            i2c_rvalid_reg  <= 1'b1;
          end
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign i2c_gnt     = i2c_gnt_reg;
  assign host_gnt    = host_gnt_reg;
  assign i2c_rvalid  = i2c_rvalid_reg;
  assign host_rvalid = host_rvalid_reg;
  assign i2c_rdata   = i2c_rdata_reg;
  assign host_rdata  = host_rdata_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Self-checking bench for i2c_reg_arbiter: directed vectors, corner-case
// sequences and random arbitration rounds against a transaction-level model.
module tb_i2c_reg_arbiter;

  logic       clk;
  logic       rst_n;
  logic       i2c_req, i2c_we;
  logic [7:0] i2c_addr, i2c_wdata;
  logic       i2c_gnt, i2c_rvalid;
  logic [7:0] i2c_rdata;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy;

  i2c_reg_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_gnt(i2c_gnt), .i2c_rvalid(i2c_rvalid), .i2c_rdata(i2c_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM with registered read.
  logic [7:0] sram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  int tests  = 0;
  int failed = 0;
  logic [7:0] ref_mem [256];
  int model_last = 1;   // 0 = I2C, 1 = host

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         cyc;
  } rv_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int policy(input logic pi, input logic ph);
    if (pi && ph) begin
`ifdef I2C_ARB_RR_EN
      return (model_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return pi ? 0 : 1;
  endfunction

  task automatic drive(input int port, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      i2c_req = 1'b1; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    end else begin
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) i2c_req = 1'b0;
    else           host_req = 1'b0;
  endtask

  task automatic note_grant(input int g, input logic we, input logic [7:0] a, input logic [7:0] d);
    model_last = g;
    if (we) ref_mem[a] = d;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 10) begin
      step();
      k++;
    end
    check("wait_idle", {31'd0, busy}, 0);
  endtask

  // Single request issued from IDLE: gnt at N+1, read data at N+3.
  task automatic do_single(input string tag, input int port, input logic we,
                           input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    logic       gm, go, rv, rvo;
    logic [7:0] rd;
    rd = 8'h00;
    wait_idle();
    drive(port, we, a, d);
    step();
    gm = (port == 0) ? i2c_gnt : host_gnt;
    go = (port == 0) ? host_gnt : i2c_gnt;
    check({tag, "_gnt"}, {31'd0, gm}, 1);
    check({tag, "_other_gnt"}, {31'd0, go}, 0);
    check({tag, "_mem_en"}, {31'd0, mem_en}, 1);
    check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, {24'd0, a});
    if (we) check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, {24'd0, d});
    drop(port);
    note_grant(port, we, a, d);
    if (!we) begin
      step();
      rv = (port == 0) ? i2c_rvalid : host_rvalid;
      check({tag, "_early_rvalid"}, {31'd0, rv}, 0);
      step();
      rv  = (port == 0) ? i2c_rvalid : host_rvalid;
      rvo = (port == 0) ? host_rvalid : i2c_rvalid;
      rd  = (port == 0) ? i2c_rdata : host_rdata;
      check({tag, "_rvalid"}, {31'd0, rv}, 1);
      check({tag, "_rdata"}, {24'd0, rd}, {24'd0, exp_rd});
      check({tag, "_other_rvalid"}, {31'd0, rvo}, 0);
    end
    $display("[TB] txn %s %s %s addr=%02h data=%02h", tag, (port == 0) ? "i2c" : "host",
             we ? "wr" : "rd", a, we ? d : rd);
  endtask

  // Both/either port request at once and hold until granted; the model
  // decides who must win each grant and what every read must return.
  task automatic run_round(input logic ri, input logic rh,
                           input logic wi, input logic [7:0] ai, input logic [7:0] di,
                           input logic wh, input logic [7:0] ah, input logic [7:0] dh,
                           output int first, output int second);
    logic       pend [2];
    logic       rq_we [2];
    logic [7:0] rq_a [2];
    logic [7:0] rq_d [2];
    logic       exp_rv [2];
    logic [7:0] exp_d [2];
    rv_t        q [$];
    int         cyc, g, ew, n;
    pend[0] = ri; pend[1] = rh;
    rq_we[0] = wi; rq_a[0] = ai; rq_d[0] = di;
    rq_we[1] = wh; rq_a[1] = ah; rq_d[1] = dh;
    first = -1; second = -1; n = 0; cyc = 0;
    if (ri) drive(0, wi, ai, di);
    if (rh) drive(1, wh, ah, dh);
    while ((pend[0] || pend[1] || q.size() != 0) && cyc < 40) begin
      step();
      cyc++;
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      exp_d[0] = 8'h00; exp_d[1] = 8'h00;
      for (int k = 0; k < q.size(); k++) begin
        if (q[k].cyc == cyc) begin
          exp_rv[q[k].port] = 1'b1;
          exp_d[q[k].port]  = q[k].data;
        end
      end
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].cyc <= cyc) q.delete(k);
      end
      check("rnd_i2c_rvalid", {31'd0, i2c_rvalid}, {31'd0, exp_rv[0]});
      if (exp_rv[0]) check("rnd_i2c_rdata", {24'd0, i2c_rdata}, {24'd0, exp_d[0]});
      check("rnd_host_rvalid", {31'd0, host_rvalid}, {31'd0, exp_rv[1]});
      if (exp_rv[1]) check("rnd_host_rdata", {24'd0, host_rdata}, {24'd0, exp_d[1]});
      if (i2c_gnt && host_gnt) begin
        check("rnd_dual_gnt", {31'd0, i2c_gnt & host_gnt}, 0);
      end else if (i2c_gnt || host_gnt) begin
        g = host_gnt ? 1 : 0;
        check("rnd_gnt_pending", {31'd0, pend[g]}, 1);
        if (pend[g]) begin
          ew = policy(pend[0], pend[1]);
          check("rnd_winner", g, ew);
          check("rnd_mem_en", {31'd0, mem_en}, 1);
          check("rnd_mem_we", {31'd0, mem_we}, {31'd0, rq_we[g]});
          check("rnd_mem_addr", {24'd0, mem_addr}, {24'd0, rq_a[g]});
          if (rq_we[g]) check("rnd_mem_wdata", {24'd0, mem_wdata}, {24'd0, rq_d[g]});
          note_grant(g, rq_we[g], rq_a[g], rq_d[g]);
          if (!rq_we[g]) q.push_back('{port: g, data: ref_mem[rq_a[g]], cyc: cyc + 2});
          pend[g] = 1'b0;
          drop(g);
          if (n == 0) first = g;
          else        second = g;
          n++;
        end
      end
    end
    check("rnd_complete", {31'd0, (pend[0] || pend[1] || q.size() != 0)}, 0);
    drop(0);
    drop(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drop(0);
    drop(1);
    step();
    step();
    rst_n = 1'b1;
    model_last = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, second, lat, cnt, m;
    logic got;
    logic [7:0] av;

    rst_n = 1'b0;
    i2c_req = 0; i2c_we = 0; i2c_addr = 0; i2c_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (3) step();

    check("rst_mem_en", {31'd0, mem_en}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", {24'd0, mem_addr}, 0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst_i2c_gnt", {31'd0, i2c_gnt}, 0);
    check("rst_host_gnt", {31'd0, host_gnt}, 0);
    check("rst_i2c_rvalid", {31'd0, i2c_rvalid}, 0);
    check("rst_host_rvalid", {31'd0, host_rvalid}, 0);
    check("rst_i2c_rdata", {24'd0, i2c_rdata}, 0);
    check("rst_host_rdata", {24'd0, host_rdata}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    model_last = 1;

    vecs[0] = '{port: 0, we: 1'b1, addr: 8'h10, wdata: 8'hA5, exp_rd: 8'h00};
    vecs[1] = '{port: 1, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'hA5};
    vecs[2] = '{port: 1, we: 1'b1, addr: 8'h20, wdata: 8'h3C, exp_rd: 8'h00};
    vecs[3] = '{port: 0, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rd: 8'h3C};
    vecs[4] = '{port: 0, we: 1'b1, addr: 8'h20, wdata: 8'hC3, exp_rd: 8'h00};
    vecs[5] = '{port: 1, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rd: 8'hC3};
    vecs[6] = '{port: 1, we: 1'b1, addr: 8'hFF, wdata: 8'h5A, exp_rd: 8'h00};
    vecs[7] = '{port: 0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rd: 8'h5A};
    vecs[8] = '{port: 0, we: 1'b1, addr: 8'h00, wdata: 8'h01, exp_rd: 8'h00};
    vecs[9] = '{port: 1, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rd: 8'h01};
    for (int i = 0; i < 10; i++) begin
      do_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rd);
    end

    // Fill the whole bank back to back, then read both address extremes.
    for (int a = 0; a < 256; a++) begin
      av = a[7:0];
      do_single("fill", 0, 1'b1, av, av ^ 8'h96, 8'h00);
    end
    do_single("wrap_ff", 1, 1'b0, 8'hFF, 8'h00, 8'hFF ^ 8'h96);
    do_single("wrap_00", 0, 1'b0, 8'h00, 8'h00, 8'h00 ^ 8'h96);

    // Simultaneous reads from reset: I2C first, host second in every round.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      run_round(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h20, 8'h00, first, second);
      check($sformatf("both_r%0d_first", r), first, 0);
      check($sformatf("both_r%0d_second", r), second, 1);
      $display("[TB] txn both_r%0d order=%0d,%0d", r, first, second);
    end

    // Host hammers continuously; a single I2C request must still get in.
    wait_idle();
    drive(1, 1'b0, 8'h10, 8'h00);
    step();
    step();
    drive(0, 1'b1, 8'h30, 8'h77);
    got = 1'b0; lat = 0; cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (!got) begin
        step();
        if (host_gnt) note_grant(1, 1'b0, 8'h10, 8'h00);
        if (i2c_gnt) begin
          got = 1'b1;
          lat = c;
          drop(0);
          note_grant(0, 1'b1, 8'h30, 8'h77);
        end
      end
    end
    check("starve_latency_ok", {31'd0, got && (lat <= 3)}, 1);
    repeat (8) begin
      step();
      if (i2c_gnt) cnt++;
      if (host_gnt) note_grant(1, 1'b0, 8'h10, 8'h00);
    end
    check("starve_i2c_gnt_count", cnt + (got ? 1 : 0), 1);
    drop(1);
    repeat (4) step();
    $display("[TB] txn starve i2c_latency=%0d", lat);
    do_single("starve_rb", 1, 1'b0, 8'h30, 8'h00, 8'h77);

    // Reset asserted during the ACCESS cycle of a read.
    wait_idle();
    drive(0, 1'b0, 8'h10, 8'h00);
    step();
    check("midrst_pre_gnt", {31'd0, i2c_gnt}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_en", {31'd0, mem_en}, 0);
    check("midrst_i2c_gnt", {31'd0, i2c_gnt}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_i2c_rvalid", {31'd0, i2c_rvalid}, 0);
    check("midrst_i2c_rdata", {24'd0, i2c_rdata}, 0);
    drop(0);
    model_last = 1;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("postrst_i2c_rvalid", {31'd0, i2c_rvalid}, 0);
      check("postrst_host_rvalid", {31'd0, host_rvalid}, 0);
    end
    $display("[TB] txn midrst read discarded");
    do_single("postrst", 1, 1'b1, 8'h40, 8'h99, 8'h00);
    do_single("postrst_rb", 0, 1'b0, 8'h40, 8'h00, 8'h99);

    // Random arbitration rounds against the transaction-level model.
    for (int r = 0; r < 40; r++) begin
      m = $urandom_range(1, 3);
      run_round(m[0], m[1],
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                first, second);
      $display("[TB] txn rnd%0d mask=%0d order=%0d,%0d", r, m, first, second);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
